// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several byte sources.
// A grant stays locked to its owner until that owner's packet-end byte has been shifted out.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int OWNER_W = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [OWNER_W-1:0]        owner,
  output logic                      locked,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t             state;
  logic [OWNER_W-1:0] ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pkt_last;
  logic               win_vld;
  logic [OWNER_W-1:0] win;
  logic [OWNER_W-1:0] cand;
  logic               done;
  logic [DATA_W-1:0]  bytes [N_REQ];

  function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    else                        return idx + 1'b1;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign bytes[i] = data[i*DATA_W +: DATA_W];
  end

  // A locked owner is the only candidate; otherwise scan from the RR pointer.
  always_comb begin
    win_vld = 1'b0;
    win     = owner;
    cand    = ptr;
    if (locked) begin
      win_vld = req[owner];
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_vld && req[cand]) begin
          win_vld = 1'b1;
          win     = cand;
        end
        cand = next_idx(cand);
      end
    end
  end

  assign done = tx_ready &&
                ((state == WAIT_HIGH) ||
                 (state == WAIT_LOW && cnt == CNT_W'(TIMEOUT - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack         <= '0;
      tx_send     <= 1'b0;
      tx_data     <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      pkt_last    <= 1'b0;
    end else begin
      ack     <= '0;
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && win_vld) begin
            ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            tx_send  <= 1'b1;
            tx_data  <= bytes[win];
            owner    <= win;
            pkt_last <= last[win];
            locked   <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_ready) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Transmitter never acknowledged the strobe; flag it and move on.
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: ;
        default: state <= IDLE;
      endcase
      if (done) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (pkt_last) begin
          locked <= 1'b0;
          ptr    <= next_idx(owner);
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several byte sources: image/status stream, command echo, and switch-send path. Each requester offers one byte at a time plus a packet-end marker. A round-robin arbiter grants the transmitter and locks it to the winner until that requester's last byte, so packets never interleave. The block alone drives the transmitter's send strobe and data and paces itself on the transmitter's ready flag.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
OWNER_W, 2, width of owner index (ceil log2 N_REQ, min 1)
TIMEOUT, 16, cycles to wait for tx_ready to fall after a send strobe

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
req  input  N_REQ  per-requester byte-valid, level
last  input  N_REQ  per-requester: offered byte ends packet
data  input  N_REQ*DATA_W  flat byte bus; requester i at [i*DATA_W +: DATA_W]
ack  output  N_REQ  one-cycle pulse: requester i's byte taken
tx_send  output  1  one-cycle send strobe to transmitter
tx_data  output  DATA_W  byte to transmitter, held stable until back in IDLE
tx_ready  input  1  transmitter idle (high) / shifting (low)
owner  output  OWNER_W  index of current/last granted requester
locked  output  1  a packet is in progress (owner holds grant)
busy  output  1  state != IDLE
err_timeout  output  1  sticky: tx_ready never fell after a strobe

Behaviour:
- Reset: state IDLE. ack, tx_send, tx_data, owner, locked, busy and err_timeout all 0. RR pointer 0, timeout counter 0. All outputs are registered.
- Reset mid-operation: abandon the byte and drop the lock; no further ack/tx_send. The transmitter finishes on its own.
- States: IDLE, WAIT_LOW, WAIT_HIGH.
- Eligibility in IDLE requires tx_ready=1. The candidate set is:
  - when locked: req[owner] only;
  - when unlocked: all req bits, searched round-robin starting at the RR pointer.
- IDLE with an eligible winner w, sampled at edge T:
  - at T+1: ack[w]=1, tx_send=1, tx_data=data[w], owner=w, pkt_last=last[w] (captured), locked=1, state WAIT_LOW;
  - ack and tx_send drop at T+2.
- Locked owner with req low: stay in IDLE and keep the lock. Other requesters are not served (deliberate: packets are atomic).
- WAIT_LOW:
  - tx_ready=0 -> WAIT_HIGH, counter cleared;
  - else count; on the TIMEOUT-th consecutive high cycle, set err_timeout and take the completion path.
- WAIT_HIGH: tx_ready=1 -> completion. No timeout here.
- Completion (returns to IDLE):
  - pkt_last=1: locked=0 and RR pointer = (owner+1) mod N_REQ;
  - pkt_last=0: lock and pointer unchanged.
- Minimum spacing between acks is 4 cycles, so a requester may change data/last or drop req any time after its ack.
- Simultaneous requests: exactly one ack per grant, never two bits high.
- err_timeout is cleared only by rst.
- tx_data is unchanged outside grants.
- Requester i must not observe ack unless req[i] was high at the sampling edge.

Test Plan:
- Single byte: req=4'b0001, data0=8'hA5, last0=1, transmitter model drops ready 1 cycle after strobe for 10 cycles -> one ack[0] and one tx_send in the same cycle; tx_data=A5 for the whole byte; locked=0 afterwards; pointer=1.
- Round-robin: req=4'b1111 constant, all last=1 -> grants in order 0,1,2,3,0; tx_data sequence follows each requester's byte.
- Packet lock: req0 sends 3 bytes (last on third) while req2 is held high -> bytes 0,0,0 are sent, then owner=2; no req2 ack before req0's last byte completes.
- Locked stall: owner 1 mid-packet drops req for 20 cycles, req3 high -> no ack, busy=0, locked=1; req1 returns and is served next.
- Timeout: tx_ready stuck high after strobe -> err_timeout=1 exactly TIMEOUT cycles after tx_send; back in IDLE; next grant proceeds; err stays 1 until rst.
- Reset mid-byte: assert rst in WAIT_HIGH -> next cycle all outputs 0, locked=0; after release with req=4'b0100 and tx_ready=1, ack[2] follows.
